// File: rtl/ps2_tx_multi.sv
// Multi-channel PS/2 device-side transmitter: per-channel byte FIFOs feeding
// 11-bit PS/2 frames clocked from one shared divided square wave.
module ps2_tx_multi #(
   parameter int NUM_CH    = 2,
   parameter int CH_BITS   = 1,
   parameter int FIFO_BITS = 3,
   parameter int CLK_DIV   = 1000,
   parameter int GAP_BITS  = 2
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               wr_strobe,
   input  logic [CH_BITS-1:0] wr_ch,
   input  logic [7:0]         wr_data,
   input  logic               flush,
   output logic [NUM_CH-1:0]  ps2_clk_out,
   output logic [NUM_CH-1:0]  ps2_data_out,
   output logic [NUM_CH-1:0]  fifo_empty,
   output logic [NUM_CH-1:0]  fifo_full,
   output logic [NUM_CH-1:0]  busy,
   output logic [NUM_CH-1:0]  ovf
);

   localparam int DEPTH = 2 ** FIFO_BITS;
   localparam int CNT_W = $clog2(CLK_DIV);
   localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_GAP} state_t;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic             rise_tick;

   // Shared divider: flush leaves it running so all channels keep one phase.
   always_comb begin
      cnt_d     = cnt_q + 1'b1;
      phase_d   = phase_q;
      rise_tick = 1'b0;
      if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
         cnt_d     = '0;
         phase_d   = ~phase_q;
         rise_tick = ~phase_q;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [FIFO_BITS:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
      logic               ovf_q, ovf_d;
      logic               empty, full, sel, push, pop;
      logic [7:0]         mem_q [DEPTH];
      state_t             state_q;
      logic [7:0]         shift_q;
      logic               par_q, data_q;
      logic [2:0]         bit_q;
      logic [GAP_W-1:0]   gap_q;

      assign empty = (wr_ptr_q == rd_ptr_q);
      assign full  = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                     (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
      assign sel   = wr_strobe && !flush && (wr_ch == CH_BITS'(c));
      // Fullness is judged before any same-cycle pop, so a coincident write is still dropped.
      assign push  = sel && !full;
      assign pop   = rise_tick && (state_q == S_IDLE) && !empty && !flush;

      always_comb begin
         wr_ptr_d = wr_ptr_q + (FIFO_BITS + 1)'(push);
         rd_ptr_d = rd_ptr_q + (FIFO_BITS + 1)'(pop);
         ovf_d    = ovf_q | (sel && full);
         if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
         end
      end

      always_ff @(posedge clk_sys) begin
         if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
         end
      end

      always_ff @(posedge clk_sys) begin
         if (push) mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= wr_data;
      end

      // Frame sequencer; data changes only as the PS/2 clock rises.
      always_ff @(posedge clk_sys) begin
         if (reset || flush) begin
            state_q <= S_IDLE;
            data_q  <= 1'b1;
            par_q   <= 1'b0;
            bit_q   <= '0;
            gap_q   <= '0;
         end else if (rise_tick) begin
            case (state_q)
               S_IDLE: begin
                  if (pop) begin
                     shift_q <= mem_q[rd_ptr_q[FIFO_BITS-1:0]];
                     par_q   <= 1'b1;
                     data_q  <= 1'b0;
                     state_q <= S_START;
                  end
               end
               S_START: begin
                  data_q  <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  par_q   <= par_q ^ shift_q[0];
                  bit_q   <= '0;
                  state_q <= S_DATA;
               end
               S_DATA: begin
                  if (bit_q == 3'd7) begin
                     data_q  <= par_q;
                     state_q <= S_PAR;
                  end else begin
                     data_q  <= shift_q[0];
                     shift_q <= shift_q >> 1;
                     par_q   <= par_q ^ shift_q[0];
                     bit_q   <= bit_q + 3'd1;
                  end
               end
               S_PAR: begin
                  data_q  <= 1'b1;
                  state_q <= S_STOP;
               end
               S_STOP: begin
                  data_q  <= 1'b1;
                  gap_q   <= GAP_W'(GAP_BITS - 1);
                  state_q <= S_GAP;
               end
               S_GAP: begin
                  if (gap_q == '0) state_q <= S_IDLE;
                  else             gap_q   <= gap_q - 1'b1;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end

      assign ps2_clk_out[c]  = phase_q | (state_q == S_IDLE) | (state_q == S_GAP);
      assign ps2_data_out[c] = data_q;
      assign fifo_empty[c]   = empty;
      assign fifo_full[c]    = full;
      assign busy[c]         = (state_q != S_IDLE);
      assign ovf[c]          = ovf_q;
   end

endmodule

// File: tb/tb_ps2_tx_multi.sv
// Bench for ps2_tx_multi: list-based channel model checked every cycle, plus
// directed frames whose host-side samples are pinned to literal bit patterns.
module tb_ps2_tx_multi;

   localparam int CD  = 4;
   localparam int GAP = 2;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1, wr_strobe = 1'b0, flush = 1'b0;
   logic [1:0] wr_ch = '0;
   logic [7:0] wr_data = '0;
   logic [1:0] ps2_clk_out, ps2_data_out, fifo_empty, fifo_full, busy, ovf;

   int vectors = 0, miscompares = 0;

   ps2_tx_multi #(.NUM_CH(2), .CH_BITS(2), .FIFO_BITS(3), .CLK_DIV(CD), .GAP_BITS(GAP)) dut (
      .clk_sys(clk_sys), .reset(reset), .wr_strobe(wr_strobe), .wr_ch(wr_ch),
      .wr_data(wr_data), .flush(flush), .ps2_clk_out(ps2_clk_out),
      .ps2_data_out(ps2_data_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .busy(busy), .ovf(ovf));

   always #5 clk_sys = ~clk_sys;

   // Reference model: a byte list per channel and a bit position in the frame.
   bit          model_ok = 1'b0;
   int          m_n;
   logic [7:0]  mbuf [2][8];
   int          mcnt [2];
   int          mpos [2];
   logic [10:0] mframe [2];
   logic        movf [2];

   function automatic logic [10:0] mkframe(input logic [7:0] b);
      return {1'b1, ~^b, b, 1'b0};
   endfunction

   always @(posedge clk_sys) begin
      if (reset) begin
         model_ok = 1'b1;
         m_n = 0;
         for (int c = 0; c < 2; c++) begin
            mcnt[c] = 0; mpos[c] = -1; movf[c] = 1'b0; mframe[c] = '1;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            bit was_full;
            was_full = (mcnt[c] == 8);
            if (flush) begin
               mcnt[c] = 0; mpos[c] = -1; movf[c] = 1'b0;
            end else begin
               if ((m_n % (2 * CD)) == CD - 1) begin
                  if (mpos[c] < 0) begin
                     if (mcnt[c] > 0) begin
                        mframe[c] = mkframe(mbuf[c][0]);
                        for (int i = 0; i < 7; i++) mbuf[c][i] = mbuf[c][i+1];
                        mcnt[c]--;
                        mpos[c] = 0;
                     end
                  end else begin
                     mpos[c]++;
                     if (mpos[c] == 11 + GAP) mpos[c] = -1;
                  end
               end
               if (wr_strobe && wr_ch == c) begin
                  if (was_full) movf[c] = 1'b1;
                  else begin mbuf[c][mcnt[c]] = wr_data; mcnt[c]++; end
               end
            end
         end
         m_n++;
      end
   end

   always @(negedge clk_sys) begin
      if (model_ok) begin
         logic [11:0] exp_v, act_v;
         logic [1:0]  e_clk, e_dat, e_emp, e_ful, e_bsy, e_ovf;
         for (int c = 0; c < 2; c++) begin
            bit in_frame;
            in_frame = (mpos[c] >= 0) && (mpos[c] <= 10);
            e_clk[c] = in_frame ? 1'(((m_n / CD) % 2)) : 1'b1;
            e_dat[c] = in_frame ? mframe[c][mpos[c]] : 1'b1;
            e_emp[c] = (mcnt[c] == 0);
            e_ful[c] = (mcnt[c] == 8);
            e_bsy[c] = (mpos[c] >= 0);
            e_ovf[c] = movf[c];
         end
         exp_v = {e_clk, e_dat, e_emp, e_ful, e_bsy, e_ovf};
         act_v = {ps2_clk_out, ps2_data_out, fifo_empty, fifo_full, busy, ovf};
         vectors++;
         if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL cycle t=%0t {clk,data,empty,full,busy,ovf}: got %b expected %b",
                     $time, act_v, exp_v);
         end
      end
   end

   // Host-side view: data sampled at every falling PS/2 clock edge.
   bit  smp0[$], smp1[$];
   int  hr1[$];
   logic [1:0] prev_clk = 2'b11;
   int  hi_run[2] = '{0, 0};

   always @(negedge clk_sys) begin
      if (model_ok) begin
         for (int c = 0; c < 2; c++) begin
            if (prev_clk[c] && !ps2_clk_out[c]) begin
               if (c == 0) smp0.push_back(ps2_data_out[0]);
               else begin smp1.push_back(ps2_data_out[1]); hr1.push_back(hi_run[1]); end
               hi_run[c] = 0;
            end else if (ps2_clk_out[c]) hi_run[c]++;
         end
         prev_clk = ps2_clk_out;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int nsmp(input int ch);
      return (ch == 0) ? smp0.size() : smp1.size();
   endfunction

   function automatic logic [10:0] frame_at(input int ch, input int k);
      logic [10:0] f = '1;
      for (int i = 0; i < 11; i++)
         if (k * 11 + i < nsmp(ch)) f[i] = (ch == 0) ? smp0[k*11+i] : smp1[k*11+i];
      return f;
   endfunction

   task automatic clr();
      smp0.delete(); smp1.delete(); hr1.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1; wr_strobe = 1'b0; flush = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      clr();
   endtask

   task automatic wr(input int ch, input logic [7:0] d);
      wr_strobe = 1'b1; wr_ch = 2'(ch); wr_data = d;
      @(negedge clk_sys);
      wr_strobe = 1'b0;
   endtask

   task automatic wait_smp(input string nm, input int ch, input int n, input int budget);
      int k = 0;
      while (nsmp(ch) < n && k < budget) begin @(negedge clk_sys); k++; end
      chk(nm, nsmp(ch) >= n, 1);
   endtask

   task automatic wait_busy(input string nm, input int ch, input int budget);
      int k = 0;
      while (!busy[ch] && k < budget) begin @(negedge clk_sys); k++; end
      chk(nm, busy[ch], 1);
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int k = 0;
      while ((busy != 2'b00 || fifo_empty != 2'b11) && k < budget) begin @(negedge clk_sys); k++; end
      chk(nm, {busy, fifo_empty}, 4'b0011);
   endtask

   task automatic align_tick();
      int k = 0;
      while ((m_n % (2 * CD)) != CD - 1 && k < 16) begin @(negedge clk_sys); k++; end
   endtask

   initial begin
      @(negedge clk_sys);
      do_reset();
      chk("reset_outputs", {ps2_clk_out, ps2_data_out, fifo_empty, fifo_full, busy, ovf},
          12'b11_11_11_00_00_00);

      // T1
      wr(0, 8'hA5);
      wait_busy("t1_busy", 0, 40);
      wait_smp("t1_wait", 0, 11, 400);
      wait_idle("t1_idle", 200);
      chk("t1_frame_A5", frame_at(0, 0), 11'h74A);
      chk("t1_falls", nsmp(0), 11);
      chk("t1_ch1_untouched", nsmp(1), 0);

      // T2
      clr();
      wr(1, 8'h00);
      wr(1, 8'hFF);
      wait_smp("t2_wait", 1, 22, 800);
      chk("t2_empty_after_pop2", fifo_empty[1], 1);
      wait_idle("t2_idle", 200);
      chk("t2_frame_00", frame_at(1, 0), 11'h600);
      chk("t2_frame_FF", frame_at(1, 1), 11'h7FE);
      chk("t2_gap_high", (hr1.size() > 11) ? (hr1[11] >= 2 * GAP * CD) : 0, 1);

      // T3
      do_reset();
      wr(0, 8'h11);
      wait_busy("t3_busy", 0, 40);
      wr_strobe = 1'b1; wr_ch = 2'd0;
      for (int i = 0; i < 9; i++) begin
         wr_data = 8'h20 + 8'(i);
         @(negedge clk_sys);
         if (i == 7) chk("t3_full_after_8", fifo_full[0], 1);
      end
      wr_strobe = 1'b0;
      chk("t3_ovf", ovf[0], 1);
      wait_smp("t3_wait", 0, 99, 2000);
      wait_idle("t3_idle", 300);
      chk("t3_frame_count", nsmp(0), 99);
      for (int k = 1; k < 9; k++) chk("t3_frame_order", frame_at(0, k), mkframe(8'h20 + 8'(k - 1)));

      // T4a: eight queued, ninth write lands on the pop tick
      do_reset();
      align_tick();
      wr_strobe = 1'b1; wr_ch = 2'd0;
      for (int i = 0; i < 9; i++) begin
         wr_data = 8'h40 + 8'(i);
         @(negedge clk_sys);
         if (i == 7) chk("t4_full", fifo_full[0], 1);
      end
      wr_strobe = 1'b0;
      chk("t4_ovf_full", {ovf[0], fifo_full[0], busy[0]}, 3'b101);
      wait_smp("t4_wait", 0, 88, 1500);
      wait_idle("t4_idle", 300);
      chk("t4_frames", nsmp(0), 88);
      for (int k = 0; k < 8; k++) chk("t4_order", frame_at(0, k), mkframe(8'h40 + 8'(k)));

      // T4b: seven queued, write and pop coincide
      do_reset();
      align_tick();
      wr_ch = 2'd0;
      for (int i = 0; i < 9; i++) begin
         wr_strobe = (i != 7);
         wr_data = 8'h60 + 8'(i);
         @(negedge clk_sys);
      end
      wr_strobe = 1'b0;
      chk("t4b_not_full", {ovf[0], fifo_full[0], fifo_empty[0]}, 3'b000);
      wait_smp("t4b_wait", 0, 88, 1500);
      wait_idle("t4b_idle", 300);
      chk("t4b_frames", nsmp(0), 88);
      chk("t4b_last", frame_at(0, 7), mkframe(8'h68));

      // T5
      do_reset();
      wr(0, 8'h55);
      wait_busy("t5_busy", 0, 40);
      wr_strobe = 1'b1; wr_ch = 2'd0;
      for (int i = 0; i < 9; i++) begin wr_data = 8'h80 + 8'(i); @(negedge clk_sys); end
      wr_strobe = 1'b0;
      wait_smp("t5_to_d3", 0, 4, 200);
      begin
         int k = 0;
         while (!ps2_clk_out[0] && k < 20) begin @(negedge clk_sys); k++; end
      end
      chk("t5_pre_flush", {ovf[0], fifo_full[0], busy[0]}, 3'b111);
      flush = 1'b1; wr_strobe = 1'b1; wr_ch = 2'd0; wr_data = 8'hEE;
      @(negedge clk_sys);
      flush = 1'b0; wr_strobe = 1'b0;
      chk("t5_after_flush", {ps2_clk_out[0], ps2_data_out[0], busy[0], fifo_empty[0], ovf[0], fifo_full[0]},
          6'b110100);
      clr();
      wr(0, 8'h3C);
      wait_smp("t5_wait", 0, 11, 400);
      wait_idle("t5_idle", 200);
      chk("t5_frame_3C", frame_at(0, 0), 11'h678);
      chk("t5_count", nsmp(0), 11);

      // T6
      wr(0, 8'h12);
      wr(1, 8'h34);
      wait_busy("t6_busy0", 0, 40);
      wait_busy("t6_busy1", 1, 40);
      repeat (20) @(negedge clk_sys);
      reset = 1'b1;
      @(negedge clk_sys);
      reset = 1'b0;
      chk("t6_reset_vals", {ps2_clk_out, ps2_data_out, fifo_empty, fifo_full, busy, ovf},
          12'b11_11_11_00_00_00);
      clr();
      wr_strobe = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wr_ch = (i % 2 == 0) ? 2'd2 : 2'd3; wr_data = 8'(i);
         @(negedge clk_sys);
      end
      wr_strobe = 1'b0;
      repeat (40) @(negedge clk_sys);
      chk("t6_ignored", {fifo_empty, busy, ovf}, 6'b11_00_00);
      chk("t6_no_frames", nsmp(0) + nsmp(1), 0);

      // Randomised traffic against the model
      do_reset();
      for (int i = 0; i < 6000; i++) begin
         wr_strobe = ($urandom_range(0, 5) == 0);
         wr_ch     = 2'($urandom_range(0, 3));
         wr_data   = 8'($urandom);
         flush     = ($urandom_range(0, 799) == 0);
         reset     = ($urandom_range(0, 2999) == 0);
         @(negedge clk_sys);
      end
      wr_strobe = 1'b0; flush = 1'b0; reset = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         wr_strobe = ($urandom_range(0, 149) == 0);
         wr_ch     = 2'($urandom_range(0, 3));
         wr_data   = 8'($urandom);
         @(negedge clk_sys);
      end
      wr_strobe = 1'b0;
      wait_idle("final_idle", 3000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
